// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and sizing rules for the per-lane FIFO
//
// Purpose : default geometry of the FIFO and the rule that sizes the
//           occupancy counter (one extra bit so it can hold MEM_LENGTH).
// Ports   : none (package).
package fifo_pkg;

  localparam int DEFAULT_BUS_SIZE   = 5;
  localparam int DEFAULT_ADDR_WIDTH = 3;

  // Occupancy ranges 0..(1 << addr_width), so it needs one bit more than an address.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - simple dual-port RAM with registered read data
//
// Purpose : storage for the FIFO; independent write and read ports.
// Ports   : clk, reset          - clock, synchronous active-high reset (rdata only)
//           we, waddr, wdata    - write port
//           re, raddr           - read port; rdata updates one edge after re
//           rdata               - registered read data, holds while re = 0
module dual_port_ram
  import fifo_pkg::*;
#(
  parameter int BUS_SIZE   = DEFAULT_BUS_SIZE,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [BUS_SIZE-1:0]   wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [BUS_SIZE-1:0]   rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [BUS_SIZE-1:0] r_mem [DEPTH];
  logic [BUS_SIZE-1:0] r_rdata;

  // Storage is never cleared; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Reading in a separate block from the write gives read-before-write
  // when waddr == raddr on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO over a registered-read RAM
//
// Purpose : per-lane datapath buffer with occupancy count, full/empty,
//           programmable almost-full/almost-empty and sticky error.
// Ports   : clk, reset                  - clock, synchronous active-high reset
//           push, data_in               - enqueue request and word
//           pop                         - dequeue request
//           af_threshold, ae_threshold  - almost-full / almost-empty levels
//           data_out, valid_out         - popped word (registered) and its strobe
//           full, empty                 - occupancy flags
//           almost_full, almost_empty   - threshold flags
//           count                       - occupancy 0..MEM_LENGTH
//           error                       - sticky overflow/underflow
module fifo_param
  import fifo_pkg::*;
#(
  parameter int BUS_SIZE   = DEFAULT_BUS_SIZE,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [BUS_SIZE-1:0]   data_in,
  input  logic [ADDR_WIDTH:0]   af_threshold,
  input  logic [ADDR_WIDTH:0]   ae_threshold,
  output logic [BUS_SIZE-1:0]   data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  error
);

  localparam int MEM_LENGTH = 1 << ADDR_WIDTH;
  localparam int CW         = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(MEM_LENGTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_valid;
  logic                  r_error;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop_ok;
  logic                  w_push_ok;
  logic                  w_overflow;
  logic                  w_underflow;
  logic [BUS_SIZE-1:0]   w_rdata;

  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);

  // Requests are gated by reset so the RAM is neither written nor read in a
  // reset cycle. A push into a full FIFO is still accepted when a pop frees
  // the slot on the same edge; a pop on empty never falls through a push.
  assign w_pop_ok    = !reset && pop && !w_empty;
  assign w_push_ok   = !reset && push && (!w_full || w_pop_ok);
  assign w_overflow  = push && w_full && !w_pop_ok;
  assign w_underflow = pop && w_empty;

  dual_port_ram #(
    .BUS_SIZE   (BUS_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (w_push_ok),
    .waddr (r_wr_ptr),
    .wdata (data_in),
    .re    (w_pop_ok),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_valid <= w_pop_ok;
      if (w_overflow || w_underflow) begin
        r_error <= 1'b1;
      end
    end
  end

  assign data_out     = w_rdata;
  assign valid_out    = r_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= af_threshold);
  assign almost_empty = (r_count <= ae_threshold);
  assign count        = r_count;
  assign error        = r_error;

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - self-checking bench for fifo_param
module tb_fifo_param;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [4:0] data_in = '0;
  logic [3:0] af_threshold = 4'd6;
  logic [3:0] ae_threshold = 4'd2;
  logic [4:0] data_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       error;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: queue of stored words plus the last popped word.
  logic [4:0] q[$];
  logic [4:0] m_dout  = '0;
  logic       m_valid = 1'b0;
  logic       m_err   = 1'b0;

  fifo_param dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .af_threshold (af_threshold),
    .ae_threshold (ae_threshold),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit pop_ok;
    bit push_ok;
    if (reset) begin
      q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else begin
      pop_ok  = pop && (q.size() > 0);
      push_ok = push && ((q.size() < DEPTH) || pop_ok);
      if ((pop && q.size() == 0) || (push && !push_ok)) m_err = 1'b1;
      if (pop_ok) m_dout = q.pop_front();
      m_valid = pop_ok;
      if (push_ok) q.push_back(data_in);
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("model data_out", data_out, m_dout);
      chk("model valid_out", valid_out, m_valid);
      chk("model count", count, q.size());
      chk("model full", full, q.size() == DEPTH);
      chk("model empty", empty, q.size() == 0);
      chk("model almost_full", almost_full, q.size() >= af_threshold);
      chk("model almost_empty", almost_empty, q.size() <= ae_threshold);
      chk("model error", error, m_err);
    end
  end

  task automatic step(input logic rst, input logic p, input logic r, input logic [4:0] d);
    @(negedge clk);
    reset   = rst;
    push    = p;
    pop     = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 5'h00);
    step(1'b0, 1'b0, 1'b0, 5'h00);
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 1'b0, 5'h00);
    step(1'b1, 1'b0, 1'b0, 5'h00);
    chk_en = 1'b1;
    chk("reset count", count, 0);
    chk("reset empty", empty, 1);
    chk("reset valid", valid_out, 0);
    chk("reset error", error, 0);
    chk("reset data_out", data_out, 0);

    // Three pushes then three pops
    step(1'b0, 1'b1, 1'b0, 5'h01);
    chk("first push count", count, 1);
    step(1'b0, 1'b1, 1'b0, 5'h02);
    step(1'b0, 1'b1, 1'b0, 5'h03);
    chk("three push count", count, 3);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 5'h00);
      chk("basic pop data", data_out, i);
      chk("basic pop valid", valid_out, 1);
    end
    step(1'b0, 1'b0, 1'b0, 5'h00);
    chk("basic drained count", count, 0);
    chk("basic drained empty", empty, 1);
    chk("basic valid drops", valid_out, 0);
    chk("basic data holds", data_out, 5'h03);
    chk("basic error", error, 0);

    // Fill with thresholds af=6, ae=2, then overflow
    chk("ae at count 0", almost_empty, 1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 5'(i));
      chk("fill ae", almost_empty, (i + 1) <= 2);
      chk("fill af", almost_full, (i + 1) >= 6);
    end
    chk("fill full", full, 1);
    step(1'b0, 1'b1, 1'b0, 5'h1F);
    chk("overflow count", count, 8);
    chk("overflow full", full, 1);
    chk("overflow error", error, 1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 1'b1, 5'h00);
      chk("overflow drain data", data_out, i);
    end
    step(1'b0, 1'b0, 1'b0, 5'h00);
    chk("overflow drained empty", empty, 1);

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 5'(i));
    step(1'b0, 1'b1, 1'b1, 5'h15);
    chk("full push+pop data", data_out, 5'h00);
    chk("full push+pop valid", valid_out, 1);
    chk("full push+pop count", count, 8);
    chk("full push+pop error", error, 0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 5'h00);
    chk("full push+pop last word", data_out, 5'h15);
    step(1'b0, 1'b0, 1'b0, 5'h00);
    chk("full push+pop drained", count, 0);

    // Pop on empty while pushing: no fall-through
    do_reset();
    step(1'b0, 1'b1, 1'b1, 5'h0A);
    chk("empty pop valid", valid_out, 0);
    chk("empty pop error", error, 1);
    chk("empty pop count", count, 1);
    chk("empty pop data holds", data_out, 0);
    step(1'b0, 1'b0, 1'b1, 5'h00);
    chk("after empty pop data", data_out, 5'h0A);
    chk("after empty pop valid", valid_out, 1);

    // Threshold inputs act combinationally
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 5'(i + 8));
    chk("thr af before", almost_full, 0);
    chk("thr ae before", almost_empty, 0);
    @(negedge clk);
    push = 1'b0;
    af_threshold = 4'd5;
    ae_threshold = 4'd5;
    #1;
    chk("thr af same cycle", almost_full, 1);
    chk("thr ae same cycle", almost_empty, 1);
    step(1'b0, 1'b0, 1'b0, 5'h00);
    af_threshold = 4'd6;
    ae_threshold = 4'd2;

    // Sustained one push and one pop per cycle
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b1, 5'((i * 7 + 3) & 31));
      chk("stream count", count, 5);
      chk("stream valid", valid_out, 1);
    end
    chk("stream data", data_out, 5'((10 * 7 + 3) & 31));

    // Reset mid-burst
    do_reset();
    step(1'b0, 1'b0, 1'b1, 5'h00);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 5'(i + 17));
    step(1'b0, 1'b0, 1'b1, 5'h00);
    chk("pre-reset count", count, 5);
    chk("pre-reset data", data_out, 5'd17);
    chk("pre-reset error", error, 1);
    step(1'b1, 1'b0, 1'b1, 5'h00);
    chk("mid-burst reset count", count, 0);
    chk("mid-burst reset valid", valid_out, 0);
    chk("mid-burst reset error", error, 0);
    chk("mid-burst reset data", data_out, 0);
    step(1'b0, 1'b0, 1'b0, 5'h00);
    step(1'b0, 1'b0, 1'b0, 5'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
